// File: rtl/mag_est.sv
// Alpha-max-plus-beta-min magnitude estimator with per-sample coefficient select,
// leaky-integrator average and peak detector with hold and exponential decay.
module mag_est #(
    parameter int unsigned W           = 16,
    parameter int unsigned AVG_SHIFT   = 4,
    parameter int unsigned HOLD        = 1024,
    parameter int unsigned DECAY_SHIFT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic                iv,
    input  logic [1:0]          mode,
    input  logic                clr,
    output logic [W-1:0]        mag,
    output logic                ov,
    output logic [W-1:0]        avg,
    output logic [W-1:0]        peak
);

    localparam int unsigned AW = W + AVG_SHIFT;
    localparam logic [15:0] HoldInit = 16'(HOLD);

    // Stage 1: absolute values
    logic         v1_q;
    logic [W-1:0] ax_q, ay_q, ax_d, ay_d;
    logic [1:0]   m1_q;

    // Two's complement negate; the most negative input lands on 2^(W-1) as unsigned.
    always_comb begin
        ax_d = x[W-1] ? $unsigned(-x) : $unsigned(x);
        ay_d = y[W-1] ? $unsigned(-y) : $unsigned(y);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            ax_q <= '0;
            ay_q <= '0;
            m1_q <= '0;
        end else begin
            v1_q <= iv;
            if (iv) begin
                ax_q <= ax_d;
                ay_q <= ay_d;
                m1_q <= mode;
            end
        end
    end

    // Stage 2: max + weighted min
    logic         v2_q;
    logic [W:0]   s_q, s_d, mx_e, mn_e;
    logic [1:0]   m2_q;

    always_comb begin
        mx_e = (ax_q >= ay_q) ? {1'b0, ax_q} : {1'b0, ay_q};
        mn_e = (ax_q >= ay_q) ? {1'b0, ay_q} : {1'b0, ax_q};
        unique case (m1_q)
            2'd0:    s_d = mx_e + (mn_e >> 1);
            2'd1:    s_d = mx_e + (mn_e >> 2);
            2'd2:    s_d = mx_e + (mn_e >> 2) + (mn_e >> 3);
            default: s_d = mx_e;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            s_q  <= '0;
            m2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                s_q  <= s_d;
                m2_q <= m1_q;
            end
        end
    end

    // Stage 3: mode 0 scales by 7/8; the result always fits in W bits
    logic [W-1:0] mag_d;

    always_comb begin
        mag_d = (m2_q == 2'd0) ? W'(s_q - (s_q >> 3)) : W'(s_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov  <= 1'b0;
            mag <= '0;
        end else begin
            ov <= v2_q;
            if (v2_q) begin
                mag <= mag_d;
            end
        end
    end

    // Trackers
    logic [AW-1:0] acc_q;
    logic [15:0]   hold_q;
    logic [W-1:0]  dec, pk_dec;

    assign avg = acc_q[AW-1:AVG_SHIFT];

    // Decay at least one LSB so small peaks still reach the current magnitude.
    always_comb begin
        dec = peak >> DECAY_SHIFT;
        if (dec == '0) begin
            dec = W'(1);
        end
        pk_dec = peak - dec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc_q  <= '0;
            peak   <= '0;
            hold_q <= '0;
        end else if (ov) begin
            acc_q <= acc_q + {{AVG_SHIFT{1'b0}}, mag} - (acc_q >> AVG_SHIFT);
            if (mag >= peak) begin
                peak   <= mag;
                hold_q <= HoldInit;
            end else if (hold_q != 16'd0) begin
                hold_q <= hold_q - 16'd1;
            end else begin
                peak <= (pk_dec > mag) ? pk_dec : mag;
            end
        end
    end

endmodule

// File: doc/mag_est.md
Name: mag_est

Overview:
- Parametrised successor to the team's 8-bit magnitude estimator.
- Estimates |x + jy| with an alpha-max-plus-beta-min approximation; the coefficient set is selectable per sample.
- Adds a leaky-integrator average and a peak detector with hold and exponential decay.
- Sits after the demodulator I/Q outputs and feeds the S-meter, AGC and spectrum display logic.

Parameters:
- W, 16: width of signed x/y inputs and of the unsigned mag/avg/peak outputs.
- AVG_SHIFT, 4: averaging time constant; the filter weight is 2^-AVG_SHIFT. Range 1..8.
- HOLD, 1024: number of valid samples the peak is held before decay starts. Range 0..65535.
- DECAY_SHIFT, 6: per-sample peak decay fraction, 2^-DECAY_SHIFT. Range 1..8.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- x  in  W  signed two's complement I component.
- y  in  W  signed two's complement Q component.
- iv  in  1  input valid; x, y and mode are sampled when high.
- mode  in  2  coefficient set for this sample.
- clr  in  1  synchronous clear of the average and peak trackers.
- mag  out  W  unsigned magnitude estimate.
- ov  out  1  one-cycle pulse; mag is valid.
- avg  out  W  unsigned smoothed magnitude.
- peak  out  W  unsigned peak-held magnitude.

Behaviour:
- Reset: on a clk edge with rst_n=0, all pipeline registers, mag, ov, avg, avg accumulator, peak and hold counter go to 0. A sample in flight is discarded; ov never asserts for it.
- Pipeline: 3 stages, fully pipelined, 1 sample/clk. ov follows iv by exactly 3 cycles. Any iv pattern is accepted; there is no backpressure.
- Stage 1, on iv: register ax=|x| and ay=|y| as W-bit unsigned, plus mode.
  - -2^(W-1) maps to 2^(W-1) with no saturation.
  - Stage registers hold their value when iv=0; only the valid bit advances.
- Stage 2: mx=max(ax,ay), mn=min(ax,ay); register a (W+1)-bit sum s. Each shifted term is truncated separately.
  - mode 0: s = mx + (mn>>1)
  - mode 1: s = mx + (mn>>2)
  - mode 2: s = mx + (mn>>2) + (mn>>3)
  - mode 3: s = mx
- Stage 3: mode 0 gives mag = s - (s>>3); modes 1-3 give mag = s. The result always fits in W bits; the worst case is mode 2 at 1.375*2^(W-1).
- mode is carried with its sample. Changing mode between samples never affects a sample already in flight.
- Average: accumulator A is (W+AVG_SHIFT) bits unsigned.
  - On a clk edge with ov=1: A <= A + mag - (A>>AVG_SHIFT), and avg = A>>AVG_SHIFT.
  - A cannot overflow.
  - avg updates on the edge after ov. Total latency from iv to avg is 4 cycles.
- Peak, on a clk edge with ov=1, evaluated in this order:
  - If mag >= peak: peak <= mag and hold <= HOLD.
  - Else if hold != 0: hold <= hold-1 and peak is unchanged.
  - Else: peak <= max(peak - max(peak>>DECAY_SHIFT, 1), mag). This guarantees progress down to mag even for small peak values.
- Trackers (avg and peak) change only on ov edges; idle cycles never decay them.
- clr: on a clk edge with clr=1, A, peak and hold go to 0.
  - clr has priority over a coincident ov; that sample does not enter the trackers.
  - mag and ov are unaffected by clr.
- rst_n has priority over clr and iv.

Test Plan:
- Modes with W=16, x=3000, y=4000, one iv pulse for each mode 0..3 on consecutive cycles -> mag = 4813, 4750, 5125, 4000 on 4 consecutive ov cycles. First ov is 3 cycles after the first iv.
- Extremes: x=y=-32768, mode 0 -> mag=43008 with no wrap. Then x=32767, y=0, mode 3 -> mag=32767. Also x=0, y=-1 -> mag=1.
- Average, AVG_SHIFT=4: after clr, continuous iv with mag=1000 -> first avg=62, then monotonically non-decreasing, and avg=1000 exactly within 300 samples and stable thereafter.
- Peak, HOLD=4, DECAY_SHIFT=3: one sample of mag 8000 followed by zero-magnitude samples -> peak=8000 for that sample plus 4 further samples, then 7000, 6125, 5360, and never below 0. Peak reaches exactly 0 eventually.
- Priority: clr together with ov (mag=5000) while peak=9000 and avg=3000 -> next cycle peak=0 and avg=0, while mag=5000 and ov=1 are still output.
- Reset mid-stream: rst_n=0 for 1 cycle while 3 samples are in flight -> no ov for those samples; mag, avg and peak read 0; the first iv after reset gives ov exactly 3 cycles later.
